// File: rtl/sum_accum_pkg.sv
// Shared definitions for the windowed saturating accumulator.
// Holds the FSM state encoding and the default window/width parameters.
package sum_accum_pkg;

    localparam int SUM_W         = 5;
    localparam int DEF_N_SAMPLES = 4;
    localparam int DEF_ACC_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/sum_accum_if.sv
// Sample-in / result-out handshake bundle for sum_accum.
// The slave modport is the accumulator side; master is the producer/consumer side.
interface sum_accum_if #(
    parameter int ACC_W = sum_accum_pkg::DEF_ACC_W
);
    import sum_accum_pkg::*;

    logic [SUM_W-1:0] sum_in;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] out_total;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  sum_in,
        input  in_valid,
        output in_ready,
        output out_total,
        output out_ovf,
        output out_valid,
        input  out_ready
    );

    modport master (
        output sum_in,
        output in_valid,
        input  in_ready,
        input  out_total,
        input  out_ovf,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/sum_accum_sat_add.sv
// W-bit unsigned adder that clamps to all-ones instead of wrapping.
// ovf reports that the true sum did not fit, i.e. the result was clamped.
module sat_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] raw;

    assign raw = {1'b0, a} + {1'b0, b};
    assign ovf = raw[W];
    assign sum = raw[W] ? {W{1'b1}} : raw[W-1:0];

endmodule

// File: rtl/sum_accum.sv
// Accumulates N_SAMPLES accepted samples into a saturating total, then holds
// the total (with a sticky overflow flag) until the downstream side takes it.
module sum_accum
    import sum_accum_pkg::*;
#(
    parameter int N_SAMPLES = DEF_N_SAMPLES,
    parameter int ACC_W     = DEF_ACC_W
) (
    input  logic        clk,
    input  logic        rst,
    sum_accum_if.slave  bus
);

    localparam int CNT_W = $clog2(N_SAMPLES + 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ACCUM = ACCUM;
    localparam logic [1:0] ST_HOLD  = HOLD;

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [ACC_W-1:0] sample_ext;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             in_ready;
    logic             accept;

    assign in_ready   = (state != ST_HOLD);
    assign accept     = bus.in_valid && in_ready;
    assign sample_ext = ACC_W'(bus.sum_in);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == ST_HOLD);
    assign bus.out_total = acc;
    assign bus.out_ovf   = ovf;

    sat_add #(
        .W   (ACC_W)
    ) u_sat_add (
        .a   (acc),
        .b   (sample_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // The first sample of a window is loaded rather than added, so a window
    // can never inherit a stale overflow from the previous one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        acc   <= sample_ext;
                        cnt   <= CNT_W'(1);
                        ovf   <= 1'b0;
                        state <= (N_SAMPLES == 1) ? ST_HOLD : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        acc <= add_sum;
                        ovf <= ovf | add_ovf;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(N_SAMPLES - 1)) begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    acc   <= '0;
                    cnt   <= '0;
                    ovf   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accum.sv
// Bench for sum_accum: three instances (N=4/W=8, N=4/W=6, N=1/W=8) driven with
// directed and random windows; expected totals come from a plain-arithmetic model.
module tb_sum_accum;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic [4:0]  sum_in_d    [3];
    logic        in_valid_d  [3];
    logic        out_ready_d [3];
    logic        in_ready_o  [3];
    logic        out_valid_o [3];
    logic        out_ovf_o   [3];
    logic [15:0] out_total_o [3];

    int checks   = 0;
    int failures = 0;
    int win_q[$];
    int gap_q[$];

    sum_accum_if #(.ACC_W(8)) bus0 ();
    sum_accum_if #(.ACC_W(6)) bus1 ();
    sum_accum_if #(.ACC_W(8)) bus2 ();

    assign bus0.sum_in = sum_in_d[0];  assign bus0.in_valid = in_valid_d[0];  assign bus0.out_ready = out_ready_d[0];
    assign bus1.sum_in = sum_in_d[1];  assign bus1.in_valid = in_valid_d[1];  assign bus1.out_ready = out_ready_d[1];
    assign bus2.sum_in = sum_in_d[2];  assign bus2.in_valid = in_valid_d[2];  assign bus2.out_ready = out_ready_d[2];

    assign in_ready_o[0]  = bus0.in_ready;   assign in_ready_o[1]  = bus1.in_ready;   assign in_ready_o[2]  = bus2.in_ready;
    assign out_valid_o[0] = bus0.out_valid;  assign out_valid_o[1] = bus1.out_valid;  assign out_valid_o[2] = bus2.out_valid;
    assign out_ovf_o[0]   = bus0.out_ovf;    assign out_ovf_o[1]   = bus1.out_ovf;    assign out_ovf_o[2]   = bus2.out_ovf;
    assign out_total_o[0] = 16'(bus0.out_total);
    assign out_total_o[1] = 16'(bus1.out_total);
    assign out_total_o[2] = 16'(bus2.out_total);

    sum_accum #(.N_SAMPLES(4), .ACC_W(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    sum_accum #(.N_SAMPLES(4), .ACC_W(6)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    sum_accum #(.N_SAMPLES(1), .ACC_W(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    function automatic int n_of(input int d);
        return (d == 2) ? 1 : 4;
    endfunction

    function automatic int max_of(input int d);
        return (d == 1) ? 63 : 255;
    endfunction

    // Runs the window in win_q (gap_q[i] idle cycles before sample i), holds
    // the result for 'stall' cycles, then completes the handshake.
    task automatic run_window(input int d, input int stall);
        int sum_true;
        int exp_total;
        logic exp_ovf;
        sum_true = 0;
        foreach (win_q[i]) sum_true += win_q[i];
        exp_total = (sum_true > max_of(d)) ? max_of(d) : sum_true;
        exp_ovf   = (sum_true > max_of(d));
        foreach (win_q[i]) begin
            for (int g = 0; g < gap_q[i]; g++) begin
                in_valid_d[d] = 1'b0;
                sum_in_d[d]   = 5'($urandom_range(0, 30));
                out_ready_d[d] = 1'($urandom_range(0, 1));
                @(negedge clk);
                checks++;
                if (in_ready_o[d] !== 1'b1 || out_valid_o[d] !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL gap_flags dev%0d: got ready=%b valid=%b expected ready=1 valid=0", d, in_ready_o[d], out_valid_o[d]);
                end
            end
            checks++;
            if (in_ready_o[d] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL accept_ready dev%0d: got %b expected 1", d, in_ready_o[d]);
            end
            in_valid_d[d]  = 1'b1;
            sum_in_d[d]    = 5'(win_q[i]);
            out_ready_d[d] = 1'($urandom_range(0, 1));
            @(negedge clk);
            in_valid_d[d] = 1'b0;
            checks++;
            if (out_valid_o[d] !== ((i == win_q.size() - 1) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("[TB] FAIL out_valid_timing dev%0d sample%0d: got %b expected %b", d, i, out_valid_o[d], (i == win_q.size() - 1));
            end
        end
        checks++;
        if (out_total_o[d] !== 16'(exp_total) || out_ovf_o[d] !== exp_ovf) begin
            failures++;
            $display("[TB] FAIL window_result dev%0d: got total=%0d ovf=%b expected total=%0d ovf=%b", d, out_total_o[d], out_ovf_o[d], exp_total, exp_ovf);
        end
        for (int k = 0; k < stall; k++) begin
            out_ready_d[d] = 1'b0;
            in_valid_d[d]  = 1'($urandom_range(0, 1));
            sum_in_d[d]    = 5'($urandom_range(1, 30));
            @(negedge clk);
            checks++;
            if (out_valid_o[d] !== 1'b1 || in_ready_o[d] !== 1'b0 ||
                out_total_o[d] !== 16'(exp_total) || out_ovf_o[d] !== exp_ovf) begin
                failures++;
                $display("[TB] FAIL hold_stable dev%0d: got valid=%b ready=%b total=%0d ovf=%b expected valid=1 ready=0 total=%0d ovf=%b",
                         d, out_valid_o[d], in_ready_o[d], out_total_o[d], out_ovf_o[d], exp_total, exp_ovf);
            end
        end
        // A sample offered on the handshake cycle must not be taken.
        out_ready_d[d] = 1'b1;
        in_valid_d[d]  = 1'b1;
        sum_in_d[d]    = 5'($urandom_range(1, 30));
        @(negedge clk);
        in_valid_d[d]  = 1'b0;
        out_ready_d[d] = 1'b0;
        checks++;
        if (out_valid_o[d] !== 1'b0 || in_ready_o[d] !== 1'b1 ||
            out_total_o[d] !== 16'd0 || out_ovf_o[d] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL after_handshake dev%0d: got valid=%b ready=%b total=%0d ovf=%b expected valid=0 ready=1 total=0 ovf=0",
                     d, out_valid_o[d], in_ready_o[d], out_total_o[d], out_ovf_o[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid_d[d]  = 1'b1;
            out_ready_d[d] = 1'b1;
            sum_in_d[d]    = 5'($urandom_range(1, 30));
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (in_ready_o[d] !== 1'b1 || out_valid_o[d] !== 1'b0 ||
                out_total_o[d] !== 16'd0 || out_ovf_o[d] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_outputs dev%0d: got ready=%b valid=%b total=%0d ovf=%b expected ready=1 valid=0 total=0 ovf=0",
                         d, in_ready_o[d], out_valid_o[d], out_total_o[d], out_ovf_o[d]);
            end
            in_valid_d[d]  = 1'b0;
            out_ready_d[d] = 1'b0;
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_stall();
        win_q = '{8, 7, 8, 9};
        gap_q = '{0, 0, 0, 0};
        run_window(0, 3);
    endtask

    task automatic test_saturate();
        win_q = '{30, 30, 30, 5};
        gap_q = '{0, 0, 0, 0};
        run_window(1, 1);
        win_q = '{1, 1, 1, 1};
        run_window(1, 0);
    endtask

    task automatic test_gaps();
        win_q = '{5, 6, 7, 8};
        gap_q = '{0, 2, 1, 0};
        run_window(0, 0);
    endtask

    task automatic test_reset_mid();
        in_valid_d[0] = 1'b1;
        sum_in_d[0]   = 5'd3;
        @(negedge clk);
        sum_in_d[0]   = 5'd4;
        @(negedge clk);
        checks++;
        if (out_total_o[0] !== 16'd7 || out_valid_o[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL partial_acc: got total=%0d valid=%b expected total=7 valid=0", out_total_o[0], out_valid_o[0]);
        end
        rst            = 1'b1;
        sum_in_d[0]    = 5'd9;
        out_ready_d[0] = 1'b1;
        @(negedge clk);
        rst            = 1'b0;
        in_valid_d[0]  = 1'b0;
        out_ready_d[0] = 1'b0;
        checks++;
        if (out_valid_o[0] !== 1'b0 || out_total_o[0] !== 16'd0 || in_ready_o[0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_mid_window: got valid=%b total=%0d ready=%b expected valid=0 total=0 ready=1",
                     out_valid_o[0], out_total_o[0], in_ready_o[0]);
        end
        win_q = '{1, 2, 3, 4};
        gap_q = '{0, 0, 0, 0};
        run_window(0, 1);
    endtask

    task automatic test_reset_hold();
        for (int i = 0; i < 4; i++) begin
            in_valid_d[1] = 1'b1;
            sum_in_d[1]   = 5'd30;
            @(negedge clk);
        end
        in_valid_d[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid_o[1] !== 1'b1 || out_total_o[1] !== 16'd63 || out_ovf_o[1] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_before_reset: got valid=%b total=%0d ovf=%b expected valid=1 total=63 ovf=1",
                     out_valid_o[1], out_total_o[1], out_ovf_o[1]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid_o[1] !== 1'b0 || out_total_o[1] !== 16'd0 || out_ovf_o[1] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_in_hold: got valid=%b total=%0d ovf=%b expected valid=0 total=0 ovf=0",
                     out_valid_o[1], out_total_o[1], out_ovf_o[1]);
        end
        win_q = '{1, 1, 1, 1};
        gap_q = '{0, 0, 0, 0};
        run_window(1, 0);
    endtask

    task automatic test_single();
        win_q = '{17};
        gap_q = '{0};
        run_window(2, 1);
        for (int w = 0; w < 5; w++) begin
            win_q = '{$urandom_range(0, 30)};
            run_window(2, 0);
        end
    endtask

    task automatic test_random();
        for (int w = 0; w < 30; w++) begin
            int d;
            d = w % 3;
            win_q.delete();
            gap_q.delete();
            for (int i = 0; i < n_of(d); i++) begin
                win_q.push_back($urandom_range(0, 30));
                gap_q.push_back($urandom_range(0, 2));
            end
            run_window(d, $urandom_range(0, 3));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid_d[d]  = 1'b0;
            out_ready_d[d] = 1'b0;
            sum_in_d[d]    = 5'd0;
        end
        @(negedge clk);
        test_reset();
        test_basic_stall();
        test_saturate();
        test_gaps();
        test_reset_mid();
        test_reset_hold();
        test_single();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
